// File: rtl/dmem_if.sv
// Load/store bus between the core (master) and the data-memory responder (slave).
interface dmem_if;
   logic        mem_read_enable_i;
   logic [31:0] mem_read_address_i;
   logic [3:0]  mem_write_enable_i;
   logic [31:0] mem_write_address_i;
   logic [31:0] mem_data_i;
   logic [31:0] mem_data_o;
   logic        load_fault_o;
   logic        store_fault_o;
   logic        mem_busy_o;

   modport master (
      output mem_read_enable_i, mem_read_address_i, mem_write_enable_i,
             mem_write_address_i, mem_data_i,
      input  mem_data_o, load_fault_o, store_fault_o, mem_busy_o
   );

   modport slave (
      input  mem_read_enable_i, mem_read_address_i, mem_write_enable_i,
             mem_write_address_i, mem_data_i,
      output mem_data_o, load_fault_o, store_fault_o, mem_busy_o
   );
endinterface

// File: rtl/dmem_responder.sv
// Single-port data memory serving loads (priority) and stores, with a small
// store buffer that parks colliding stores and forwards them to younger loads.
module dmem_responder #(
   parameter int unsigned MEM_WORDS = 16384,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned SB_DEPTH  = 2
) (
   input  logic   clk,
   input  logic   reset,
   dmem_if.slave  bus
);
   localparam int IDX_W = $clog2(MEM_WORDS);
   localparam int PTR_W = $clog2(SB_DEPTH);

   typedef logic [IDX_W-1:0] idx_t;
   typedef logic [PTR_W-1:0] ptr_t;
   typedef struct packed {
      idx_t        idx;
      logic [3:0]  be;
      logic [31:0] data;
   } sb_entry_t;

   logic [31:0] mem [MEM_WORDS];
   sb_entry_t   sb  [SB_DEPTH];

   ptr_t         rd_ptr, wr_ptr;
   logic [PTR_W:0] count;

   logic [31:0] ld_off, st_off;
   logic        ld_in_range, st_in_range, ld_ok, st_req, st_accept;
   idx_t        ld_idx, st_idx;
   logic        empty, full, push, pop, direct;

   assign ld_off      = bus.mem_read_address_i  - BASE_ADDR;
   assign st_off      = bus.mem_write_address_i - BASE_ADDR;
   assign ld_in_range = (bus.mem_read_address_i  >= BASE_ADDR) && ({2'b00, ld_off[31:2]} < MEM_WORDS);
   assign st_in_range = (bus.mem_write_address_i >= BASE_ADDR) && ({2'b00, st_off[31:2]} < MEM_WORDS);
   assign ld_idx      = ld_off[IDX_W+1:2];
   assign st_idx      = st_off[IDX_W+1:2];

   assign empty     = (count == '0);
   assign full      = (count == (PTR_W+1)'(SB_DEPTH));
   assign ld_ok     = bus.mem_read_enable_i && ld_in_range;
   assign st_req    = (bus.mem_write_enable_i != 4'b0000);
   assign st_accept = st_req && !full && st_in_range;

   // An in-range load owns the array port; stores then queue behind the buffer.
   assign push   = st_accept && (ld_ok || !empty);
   assign pop    = !ld_ok && !empty;
   assign direct = st_accept && !ld_ok && empty;

   assign bus.mem_busy_o = full;

   sb_entry_t   head;
   logic        wr_en;
   idx_t        wr_idx;
   logic [3:0]  wr_be;
   logic [31:0] wr_data;

   assign head    = sb[rd_ptr];
   assign wr_en   = pop || direct;
   assign wr_idx  = pop ? head.idx  : st_idx;
   assign wr_be   = pop ? head.be   : bus.mem_write_enable_i;
   assign wr_data = pop ? head.data : bus.mem_data_i;

   // Byte-merge of buffered stores (oldest first) then the same-cycle store.
   logic [3:0]  fwd_mask;
   logic [31:0] fwd_data;
   ptr_t        slot;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      fwd_mask = 4'b0000;
      fwd_data = '0;
      slot     = rd_ptr;
      for (int k = 0; k < SB_DEPTH; k++) begin
         slot = rd_ptr + PTR_W'(k);
         if (k < int'(count) && sb[slot].idx == ld_idx) begin
            for (int b = 0; b < 4; b++) begin
               if (sb[slot].be[b]) begin
                  fwd_mask[b]       = 1'b1;
                  fwd_data[8*b +: 8] = sb[slot].data[8*b +: 8];
               end
            end
         end
      end
      if (st_accept && st_idx == ld_idx) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.mem_write_enable_i[b]) begin
               fwd_mask[b]       = 1'b1;
               fwd_data[8*b +: 8] = bus.mem_data_i[8*b +: 8];
            end
         end
      end
   end

   logic [31:0] rd_word;

   // NOTE: the array and buffer payload have no reset; only pointers and flags
   // need one, and a reset on a RAM would stop it mapping to block memory.
   always_ff @(posedge clk) begin
      if (ld_ok) begin
         rd_word <= mem[ld_idx];
      end else if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
      if (push) sb[wr_ptr] <= '{idx: st_idx, be: bus.mem_write_enable_i, data: bus.mem_data_i};
   end

   logic        load_pend_q, load_fault_q, store_fault_q;
   logic [3:0]  fwd_mask_q;
   logic [31:0] fwd_data_q, last_q, merged, mask32;

   assign mask32 = {{8{fwd_mask_q[3]}}, {8{fwd_mask_q[2]}}, {8{fwd_mask_q[1]}}, {8{fwd_mask_q[0]}}};
   assign merged = (rd_word & ~mask32) | (fwd_data_q & mask32);

   assign bus.mem_data_o    = load_pend_q ? merged : last_q;
   assign bus.load_fault_o  = load_fault_q;
   assign bus.store_fault_o = store_fault_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr        <= '0;
         wr_ptr        <= '0;
         count         <= '0;
         load_pend_q   <= 1'b0;
         load_fault_q  <= 1'b0;
         store_fault_q <= 1'b0;
         fwd_mask_q    <= 4'b0000;
         fwd_data_q    <= '0;
         last_q        <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         load_pend_q   <= ld_ok;
         load_fault_q  <= bus.mem_read_enable_i && !ld_in_range;
         store_fault_q <= st_req && !full && !st_in_range;
         if (ld_ok) begin
            fwd_mask_q <= fwd_mask;
            fwd_data_q <= fwd_data;
         end

         // last_q carries the visible data through cycles with no load.
         if (bus.mem_read_enable_i && !ld_in_range) last_q <= '0;
         else if (load_pend_q)                      last_q <= merged;
      end
   end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: forwarding, buffering, faults and reset.
module tb_dmem_responder;
   logic clk;
   logic reset;
   int   total;
   int   bad;

   dmem_if bus ();

   dmem_responder dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic re, input logic [31:0] ra, input logic [3:0] we,
                        input logic [31:0] wa, input logic [31:0] wd);
      bus.mem_read_enable_i   = re;
      bus.mem_read_address_i  = ra;
      bus.mem_write_enable_i  = we;
      bus.mem_write_address_i = wa;
      bus.mem_data_i          = wd;
   endtask

   task automatic idle();
      drive(1'b0, 32'h0, 4'b0000, 32'h0, 32'h0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle();
      tick();
      tick();
      total++; if (bus.mem_data_o !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=%h", bus.mem_data_o, 32'h0); end
      total++; if (bus.load_fault_o !== 1'b0) begin bad++; $display("FAIL reset_lfault got=%b want=0", bus.load_fault_o); end
      total++; if (bus.store_fault_o !== 1'b0) begin bad++; $display("FAIL reset_sfault got=%b want=0", bus.store_fault_o); end
      total++; if (bus.mem_busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.mem_busy_o); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_store_load();
      drive(1'b0, 32'h0, 4'b1111, 32'h100, 32'hDEADBEEF);
      tick();
      idle();
      tick();
      drive(1'b1, 32'h100, 4'b0000, 32'h0, 32'h0);
      tick();
      idle();
      total++; if (bus.mem_data_o !== 32'hDEADBEEF) begin bad++; $display("FAIL t1_data got=%h want=%h", bus.mem_data_o, 32'hDEADBEEF); end
      total++; if (bus.load_fault_o !== 1'b0) begin bad++; $display("FAIL t1_lfault got=%b want=0", bus.load_fault_o); end
      total++; if (bus.store_fault_o !== 1'b0) begin bad++; $display("FAIL t1_sfault got=%b want=0", bus.store_fault_o); end
      tick();
      total++; if (bus.mem_data_o !== 32'hDEADBEEF) begin bad++; $display("FAIL t1_hold got=%h want=%h", bus.mem_data_o, 32'hDEADBEEF); end
   endtask

   task automatic test_same_cycle_forward();
      drive(1'b0, 32'h0, 4'b1111, 32'h200, 32'hAAAAAAAA);
      tick();
      drive(1'b1, 32'h200, 4'b0011, 32'h200, 32'h11223344);
      tick();
      idle();
      total++; if (bus.mem_data_o !== 32'hAAAA3344) begin bad++; $display("FAIL t2_fwd got=%h want=%h", bus.mem_data_o, 32'hAAAA3344); end
      total++; if (bus.mem_busy_o !== 1'b0) begin bad++; $display("FAIL t2_busy got=%b want=0", bus.mem_busy_o); end
      tick();
      drive(1'b1, 32'h200, 4'b0000, 32'h0, 32'h0);
      tick();
      idle();
      total++; if (bus.mem_data_o !== 32'hAAAA3344) begin bad++; $display("FAIL t2_drained got=%h want=%h", bus.mem_data_o, 32'hAAAA3344); end
   endtask

   task automatic test_buffer_full();
      drive(1'b1, 32'h100, 4'b1111, 32'h10, 32'h01010101);
      tick();
      total++; if (bus.mem_busy_o !== 1'b0) begin bad++; $display("FAIL t3_busy1 got=%b want=0", bus.mem_busy_o); end
      drive(1'b1, 32'h100, 4'b1111, 32'h14, 32'h02020202);
      tick();
      total++; if (bus.mem_busy_o !== 1'b1) begin bad++; $display("FAIL t3_busy2 got=%b want=1", bus.mem_busy_o); end
      drive(1'b1, 32'h100, 4'b1111, 32'h10, 32'h03030303);
      tick();
      total++; if (bus.mem_busy_o !== 1'b1) begin bad++; $display("FAIL t3_busy3 got=%b want=1", bus.mem_busy_o); end
      total++; if (bus.mem_data_o !== 32'hDEADBEEF) begin bad++; $display("FAIL t3_load got=%h want=%h", bus.mem_data_o, 32'hDEADBEEF); end
      idle();
      tick();
      total++; if (bus.mem_busy_o !== 1'b0) begin bad++; $display("FAIL t3_drain1 got=%b want=0", bus.mem_busy_o); end
      tick();
      drive(1'b1, 32'h10, 4'b0000, 32'h0, 32'h0);
      tick();
      total++; if (bus.mem_data_o !== 32'h01010101) begin bad++; $display("FAIL t3_arr10 got=%h want=%h", bus.mem_data_o, 32'h01010101); end
      drive(1'b1, 32'h14, 4'b0000, 32'h0, 32'h0);
      tick();
      idle();
      total++; if (bus.mem_data_o !== 32'h02020202) begin bad++; $display("FAIL t3_arr14 got=%h want=%h", bus.mem_data_o, 32'h02020202); end
   endtask

   task automatic test_byte_merge();
      drive(1'b0, 32'h0, 4'b1111, 32'h40, 32'h12345678);
      tick();
      drive(1'b1, 32'h100, 4'b0001, 32'h40, 32'h000000AA);
      tick();
      drive(1'b1, 32'h100, 4'b0010, 32'h40, 32'h0000BB00);
      tick();
      drive(1'b1, 32'h40, 4'b0000, 32'h0, 32'h0);
      tick();
      idle();
      total++; if (bus.mem_data_o !== 32'h1234BBAA) begin bad++; $display("FAIL t4_merge got=%h want=%h", bus.mem_data_o, 32'h1234BBAA); end
      total++; if (bus.mem_busy_o !== 1'b1) begin bad++; $display("FAIL t4_full got=%b want=1", bus.mem_busy_o); end
      tick();
      tick();
      drive(1'b1, 32'h40, 4'b0000, 32'h0, 32'h0);
      tick();
      total++; if (bus.mem_data_o !== 32'h1234BBAA) begin bad++; $display("FAIL t4_arr got=%h want=%h", bus.mem_data_o, 32'h1234BBAA); end
      drive(1'b1, 32'h100, 4'b0001, 32'h40, 32'h00000011);
      tick();
      drive(1'b1, 32'h100, 4'b0001, 32'h40, 32'h00000022);
      tick();
      drive(1'b1, 32'h40, 4'b0000, 32'h0, 32'h0);
      tick();
      idle();
      total++; if (bus.mem_data_o !== 32'h1234BB22) begin bad++; $display("FAIL t4_young got=%h want=%h", bus.mem_data_o, 32'h1234BB22); end
      tick();
      tick();
      drive(1'b1, 32'h40, 4'b0000, 32'h0, 32'h0);
      tick();
      idle();
      total++; if (bus.mem_data_o !== 32'h1234BB22) begin bad++; $display("FAIL t4_fifo got=%h want=%h", bus.mem_data_o, 32'h1234BB22); end
   endtask

   task automatic test_faults();
      drive(1'b0, 32'h0, 4'b1111, 32'h0, 32'h5A5A5A5A);
      tick();
      drive(1'b0, 32'h0, 4'b1111, 32'hFFFC, 32'hCAFEF00D);
      tick();
      drive(1'b1, 32'hFFFC, 4'b0000, 32'h0, 32'h0);
      tick();
      total++; if (bus.mem_data_o !== 32'hCAFEF00D || bus.load_fault_o !== 1'b0) begin bad++; $display("FAIL t5_last got=%h/%b want=%h/0", bus.mem_data_o, bus.load_fault_o, 32'hCAFEF00D); end
      drive(1'b1, 32'h10000, 4'b0000, 32'h0, 32'h0);
      tick();
      idle();
      total++; if (bus.load_fault_o !== 1'b1) begin bad++; $display("FAIL t5_lfault got=%b want=1", bus.load_fault_o); end
      total++; if (bus.mem_data_o !== 32'h0) begin bad++; $display("FAIL t5_ldata got=%h want=%h", bus.mem_data_o, 32'h0); end
      tick();
      total++; if (bus.load_fault_o !== 1'b0) begin bad++; $display("FAIL t5_lfault_clr got=%b want=0", bus.load_fault_o); end
      drive(1'b0, 32'h0, 4'b1111, 32'h10000, 32'hFFFFFFFF);
      tick();
      idle();
      total++; if (bus.store_fault_o !== 1'b1) begin bad++; $display("FAIL t5_sfault got=%b want=1", bus.store_fault_o); end
      tick();
      total++; if (bus.store_fault_o !== 1'b0) begin bad++; $display("FAIL t5_spulse got=%b want=0", bus.store_fault_o); end
      drive(1'b1, 32'h0, 4'b0000, 32'h0, 32'h0);
      tick();
      idle();
      total++; if (bus.mem_data_o !== 32'h5A5A5A5A) begin bad++; $display("FAIL t5_word0 got=%h want=%h", bus.mem_data_o, 32'h5A5A5A5A); end
   endtask

   task automatic test_reset_discard();
      drive(1'b1, 32'h100, 4'b1111, 32'h100, 32'h0BADF00D);
      tick();
      drive(1'b1, 32'h100, 4'b1111, 32'h40, 32'h99999999);
      tick();
      total++; if (bus.mem_busy_o !== 1'b1) begin bad++; $display("FAIL t6_full got=%b want=1", bus.mem_busy_o); end
      reset = 1'b1;
      idle();
      #1;
      total++; if (bus.mem_data_o !== 32'h0) begin bad++; $display("FAIL t6_data got=%h want=%h", bus.mem_data_o, 32'h0); end
      total++; if (bus.mem_busy_o !== 1'b0) begin bad++; $display("FAIL t6_busy got=%b want=0", bus.mem_busy_o); end
      total++; if (bus.load_fault_o !== 1'b0 || bus.store_fault_o !== 1'b0) begin bad++; $display("FAIL t6_faults got=%b%b want=00", bus.load_fault_o, bus.store_fault_o); end
      tick();
      tick();
      reset = 1'b0;
      tick();
      tick();
      drive(1'b1, 32'h100, 4'b0000, 32'h0, 32'h0);
      tick();
      total++; if (bus.mem_data_o !== 32'hDEADBEEF) begin bad++; $display("FAIL t6_arr100 got=%h want=%h", bus.mem_data_o, 32'hDEADBEEF); end
      drive(1'b1, 32'h40, 4'b0000, 32'h0, 32'h0);
      tick();
      idle();
      total++; if (bus.mem_data_o !== 32'h1234BB22) begin bad++; $display("FAIL t6_arr40 got=%h want=%h", bus.mem_data_o, 32'h1234BB22); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_store_load();
      test_same_cycle_forward();
      test_buffer_full();
      test_byte_merge();
      test_faults();
      test_reset_discard();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
